// File: rtl/pointwise_mul.sv
// In-place pointwise modular product A[i] = A[i]*B[i] mod MOD over two NTT operand memories.
// Define POINTWISE_NINV_SCALE_EN to also multiply each result by NINV (inverse-NTT normalisation).
module pointwise_mul #(
   parameter int          DEPTH = 8,
   parameter int          SIZE  = 32,
   parameter int unsigned MOD   = 998244353,
   parameter int unsigned NINV  = 873463809
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH)-1:0]   a_addr_r,
   output logic                       a_RE,
   input  logic [SIZE-1:0]            a_Q,
   input  logic                       a_valid,
   output logic [$clog2(DEPTH)-1:0]   a_addr_w,
   output logic [SIZE-1:0]            a_D,
   output logic                       a_WE,
   output logic [$clog2(DEPTH)-1:0]   b_addr_r,
   output logic                       b_RE,
   input  logic [SIZE-1:0]            b_Q,
   input  logic                       b_valid
);

   localparam int              AW    = $clog2(DEPTH);
   localparam logic [AW:0]     LAST  = (AW+1)'(DEPTH - 1);
   localparam logic [2*SIZE-1:0] MOD_W = (2*SIZE)'(MOD);

   typedef enum logic [3:0] {
      IDLE, ISSUE, WAIT, MUL, RED, WRITE, NEXT, DONE
`ifdef POINTWISE_NINV_SCALE_EN
      , SMUL, SRED
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [AW:0]         idx_q, idx_d;
   logic [AW-1:0]       rd_addr_q, rd_addr_d;
   logic                a_re_q, a_re_d, b_re_q, b_re_d;
   logic                a_cap_q, a_cap_d, b_cap_q, b_cap_d;
   logic [SIZE-1:0]     a_op_q, a_op_d, b_op_q, b_op_d;
   logic [2*SIZE-1:0]   prod_q, prod_d;
   logic [SIZE-1:0]     res_q, res_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         rd_addr_q <= '0;
         a_re_q    <= 1'b0;
         b_re_q    <= 1'b0;
         a_cap_q   <= 1'b0;
         b_cap_q   <= 1'b0;
         a_op_q    <= '0;
         b_op_q    <= '0;
         prod_q    <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rd_addr_q <= rd_addr_d;
         a_re_q    <= a_re_d;
         b_re_q    <= b_re_d;
         a_cap_q   <= a_cap_d;
         b_cap_q   <= b_cap_d;
         a_op_q    <= a_op_d;
         b_op_q    <= b_op_d;
         prod_q    <= prod_d;
         res_q     <= res_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rd_addr_d = rd_addr_q;
      a_re_d    = a_re_q;
      b_re_d    = b_re_q;
      a_cap_d   = a_cap_q;
      b_cap_d   = b_cap_q;
      a_op_d    = a_op_q;
      b_op_d    = b_op_q;
      prod_d    = prod_q;
      res_d     = res_q;
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      a_WE      = 1'b0;
      a_addr_w  = '0;
      a_D       = '0;

      case (state_q)
         IDLE: begin
            // Read request is registered on entry so ISSUE presents it to the memories.
            if (enable) begin
               state_d   = ISSUE;
               idx_d     = '0;
               rd_addr_d = '0;
               a_re_d    = 1'b1;
               b_re_d    = 1'b1;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (a_valid && !a_cap_q) begin
               a_op_d  = a_Q;
               a_cap_d = 1'b1;
               a_re_d  = 1'b0;
            end
            if (b_valid && !b_cap_q) begin
               b_op_d  = b_Q;
               b_cap_d = 1'b1;
               b_re_d  = 1'b0;
            end
            if (a_cap_d && b_cap_d) state_d = MUL;
         end
         MUL: begin
            prod_d  = (2*SIZE)'(a_op_q) * (2*SIZE)'(b_op_q);
            a_cap_d = 1'b0;
            b_cap_d = 1'b0;
            state_d = RED;
         end
         RED: begin
            res_d = SIZE'(prod_q % MOD_W);
`ifdef POINTWISE_NINV_SCALE_EN
            state_d = SMUL;
`else
            state_d = WRITE;
`endif
         end
`ifdef POINTWISE_NINV_SCALE_EN
         SMUL: begin
            prod_d  = (2*SIZE)'(res_q) * (2*SIZE)'(NINV);
            state_d = SRED;
         end
         SRED: begin
            res_d   = SIZE'(prod_q % MOD_W);
            state_d = WRITE;
         end
`endif
         WRITE: begin
            a_WE     = 1'b1;
            a_addr_w = idx_q[AW-1:0];
            a_D      = res_q;
            state_d  = NEXT;
         end
         NEXT: begin
            if (idx_q < LAST) begin
               idx_d     = idx_q + (AW+1)'(1);
               rd_addr_d = idx_d[AW-1:0];
               a_re_d    = 1'b1;
               b_re_d    = 1'b1;
               state_d   = ISSUE;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign a_addr_r = rd_addr_q;
   assign b_addr_r = rd_addr_q;
   assign a_RE     = a_re_q;
   assign b_RE     = b_re_q;

endmodule

// File: tb/tb_pointwise_mul.sv
// Directed bench for pointwise_mul: behavioural operand memories with programmable valid latency.
module tb_pointwise_mul;

   localparam int          DEPTH = 8;
   localparam int          SIZE  = 32;
   localparam int unsigned MOD   = 998244353;

   logic            clk, rst, enable, busy, done;
   logic [2:0]      a_addr_r, a_addr_w, b_addr_r;
   logic            a_RE, a_WE, b_RE, a_valid, b_valid;
   logic [SIZE-1:0] a_Q, a_D, b_Q;

   logic [31:0] memA [DEPTH];
   logic [31:0] memB [DEPTH];
   logic [31:0] expA [DEPTH];

   int a_lat = 1, b_lat = 1;
   int a_cnt = 0, b_cnt = 0;
   logic [2:0] a_pend, b_pend;
   int n_writes = 0, n_done = 0, n_are = 0, n_bre = 0;
   int tests_run = 0, tests_failed = 0;
   int cyc;

   pointwise_mul #(
      .DEPTH (DEPTH),
      .SIZE  (SIZE),
      .MOD   (MOD),
      .NINV  (873463809)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .busy     (busy),
      .done     (done),
      .a_addr_r (a_addr_r),
      .a_RE     (a_RE),
      .a_Q      (a_Q),
      .a_valid  (a_valid),
      .a_addr_w (a_addr_w),
      .a_D      (a_D),
      .a_WE     (a_WE),
      .b_addr_r (b_addr_r),
      .b_RE     (b_RE),
      .b_Q      (b_Q),
      .b_valid  (b_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Memories see the DUT's outputs for the current cycle and answer in later cycles.
   initial begin
      a_valid = 1'b0; b_valid = 1'b0; a_Q = '0; b_Q = '0;
      forever begin
         @(posedge clk); #1;
         a_valid = 1'b0;
         b_valid = 1'b0;
         if (rst) begin
            a_cnt = 0;
            b_cnt = 0;
         end else begin
            if (a_WE) begin
               memA[a_addr_w] = a_D;
               n_writes++;
            end
            if (a_RE) n_are++;
            if (b_RE) n_bre++;
            if (done) n_done++;
            if (a_cnt > 0) begin
               a_cnt--;
               if (a_cnt == 0) begin a_valid = 1'b1; a_Q = memA[a_pend]; end
            end else if (a_RE) begin
               a_cnt = a_lat; a_pend = a_addr_r;
            end
            if (b_cnt > 0) begin
               b_cnt--;
               if (b_cnt == 0) begin b_valid = 1'b1; b_Q = memB[b_pend]; end
            end else if (b_RE) begin
               b_cnt = b_lat; b_pend = b_addr_r;
            end
         end
      end
   end

   task automatic run_op(input int pulse_at, output int cycles);
      n_writes = 0; n_done = 0; n_are = 0; n_bre = 0;
      @(negedge clk); enable = 1'b1; cycles = 1;
      @(posedge clk); #1; enable = 1'b0; cycles = 2;
      while (!done && cycles < 500) begin
         enable = (cycles == pulse_at);
         @(posedge clk); #1; cycles++;
      end
      enable = 1'b0;
      check_eq("done_seen", done, 1);
      @(posedge clk); #1;
      check_eq("done_one_cycle", done, 0);
      check_eq("busy_idle", busy, 0);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < DEPTH; i++) check_eq($sformatf("%s[%0d]", tag, i), memA[i], expA[i]);
   endtask

   task automatic load_basic();
      for (int i = 0; i < DEPTH; i++) begin
         memA[i] = 32'(i + 1);
         memB[i] = 32'd2;
         expA[i] = 32'(2 * i + 2);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0;
      repeat (3) @(posedge clk); #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_re", {a_RE, b_RE, a_WE}, 0);
      check_eq("rst_addr", {a_addr_r, b_addr_r, a_addr_w}, 0);
      check_eq("rst_d", a_D, 0);
      @(negedge clk); rst = 1'b0;

`ifdef POINTWISE_NINV_SCALE_EN
      for (int i = 0; i < DEPTH; i++) begin memA[i] = 32'd8; memB[i] = 32'd1; expA[i] = 32'd1; end
      run_op(0, cyc);
      check_eq("scale_cycles", cyc, 66);
      check_eq("scale_writes", n_writes, 8);
      check_mem("scale");
`else
      load_basic();
      run_op(0, cyc);
      check_eq("basic_cycles", cyc, 50);
      check_eq("basic_done_cnt", n_done, 1);
      check_eq("basic_writes", n_writes, 8);
      check_mem("basic");

      memA[0] = 32'd998244352;   memB[0] = 32'd998244352;   expA[0] = 32'd1;
      memA[1] = 32'h8000_0000;   memB[1] = 32'h8000_0000;   expA[1] = 32'd732135154;
      memA[2] = 32'd998244358;   memB[2] = 32'd3;           expA[2] = 32'd15;
      memA[3] = 32'hFFFF_FFFF;   memB[3] = 32'd1;           expA[3] = 32'd301989883;
      for (int i = 4; i < DEPTH; i++) begin
         memA[i] = 32'd100000; memB[i] = 32'd100000; expA[i] = 32'd17556470;
      end
      run_op(0, cyc);
      check_eq("ovf_cycles", cyc, 50);
      check_mem("ovf");

      for (int i = 0; i < DEPTH; i++) begin
         memA[i] = 32'(i + 3); memB[i] = 32'(i + 5); expA[i] = 32'((i + 3) * (i + 5));
      end
      b_lat = 4;
      run_op(0, cyc);
      b_lat = 1;
      check_eq("skew_cycles", cyc, 74);
      check_eq("skew_writes", n_writes, 8);
      check_eq("skew_a_re_cycles", n_are, 16);
      check_eq("skew_b_re_cycles", n_bre, 40);
      check_mem("skew");

      load_basic();
      n_writes = 0;
      @(negedge clk); enable = 1'b1;
      @(posedge clk); #1; enable = 1'b0;
      begin
         int k = 0;
         while (!(a_RE && a_addr_r == 3'd3) && k < 200) begin @(posedge clk); #1; k++; end
      end
      check_eq("reach_elem3", {a_RE, a_addr_r}, {1'b1, 3'd3});
      @(posedge clk); #2;
      rst = 1'b1; #1;
      check_eq("abort_we", a_WE, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_re", {a_RE, b_RE}, 0);
      check_eq("abort_writes", n_writes, 3);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) check_eq($sformatf("abort_done_elem[%0d]", i), memA[i], 32'(2 * i + 2));
      for (int i = 3; i < DEPTH; i++) check_eq($sformatf("abort_kept[%0d]", i), memA[i], 32'(i + 1));
      load_basic();
      run_op(0, cyc);
      check_eq("restart_cycles", cyc, 50);
      check_eq("restart_writes", n_writes, 8);
      check_mem("restart");

      load_basic();
      run_op(12, cyc);
      repeat (60) begin @(posedge clk); #1; end
      check_eq("busy_en_done_cnt", n_done, 1);
      check_eq("busy_en_writes", n_writes, 8);
      check_eq("busy_en_cycles", cyc, 50);
      check_eq("busy_en_idle", busy, 0);
      check_mem("busy_en");
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pointwise_mul.md
POINTWISE_MUL -- requirements
Module: pointwise_mul

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of coefficients; a power of two, at least 2.
REQ-002 SHALL have parameter SIZE, default 32: coefficient width in bits.
REQ-003 SHALL have parameter MOD, default 998244353: prime modulus.
REQ-004 SHALL have parameter NINV, default 873463809: DEPTH^-1 mod MOD; used only with the scale feature (REQ-028).
REQ-005 SHALL have ports, one per line, clock and reset first:
- clk  in  1  clock; reset rst, asynchronous, active-high; clock clk.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  start request, sampled in IDLE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- a_addr_r  out  $clog2(DEPTH)  operand A read address.
- a_RE  out  1  operand A read enable.
- a_Q  in  SIZE  operand A read data.
- a_valid  in  1  a_Q valid.
- a_addr_w  out  $clog2(DEPTH)  result write address (memory A).
- a_D  out  SIZE  result write data.
- a_WE  out  1  result write enable.
- b_addr_r  out  $clog2(DEPTH)  operand B read address.
- b_RE  out  1  operand B read enable.
- b_Q  in  SIZE  operand B read data.
- b_valid  in  1  b_Q valid.

Function
REQ-006 SHALL compute A[i] = (A[i]*B[i]) mod MOD in place, for i = 0..DEPTH-1 in ascending order; it consumes two NTT-transformed operand memories.
REQ-007 SHALL have states IDLE, ISSUE, WAIT, MUL, RED, WRITE, NEXT, DONE; the scale feature adds SMUL and SRED.
REQ-008 SHALL take transitions:
- IDLE->ISSUE on enable=1; index reset to 0.
- ISSUE->WAIT.
- WAIT->MUL once both operands are captured.
- MUL->RED.
- RED->WRITE, or RED->SMUL when scaling.
- SMUL->SRED->WRITE.
- WRITE->NEXT.
- NEXT->ISSUE if index < DEPTH-1, else NEXT->DONE.
- DONE->IDLE.
REQ-009 ISSUE SHALL register a_addr_r = b_addr_r = index and a_RE = b_RE = 1.
REQ-010 WAIT SHALL hold the RE of each port high until that port's operand is captured, then drop it the next cycle.
REQ-011 a_valid and b_valid SHALL be captured independently, in any order and in any cycle.
REQ-012 A valid seen in any state other than WAIT, or a second valid on an already-captured port, SHALL be ignored.
REQ-013 MUL SHALL form the full 2*SIZE-bit product; RED SHALL reduce it mod MOD; inputs >= MOD SHALL still give the correct residue.
REQ-014 WRITE SHALL drive a_WE=1, a_addr_w=index, a_D=result for exactly one clock per element; a_WE SHALL be 0 in all other cycles.
REQ-015 With a 1-cycle valid latency, each element SHALL take 6 cycles (8 with scale); the full run SHALL take DEPTH*6+2 cycles from enable to done.
REQ-016 done SHALL be high exactly one cycle, in state DONE; busy SHALL be low only in IDLE.
REQ-017 enable while busy SHALL be ignored; enable held high through DONE SHALL start a new run on the next IDLE cycle.
REQ-018 The index SHALL be $clog2(DEPTH)+1 bits wide, with no wrap before the terminal compare.

Reset
REQ-019 rst=1 SHALL immediately force state IDLE and clear the index, captured flags and operand/product registers.
REQ-020 On reset, all address outputs, a_D, a_RE, b_RE and a_WE SHALL be 0, and busy and done SHALL be 0.
REQ-021 A reset mid-run SHALL abort without completing any pending write; the next enable SHALL restart from index 0.

Configuration
REQ-022 Macro POINTWISE_NINV_SCALE_EN SHALL select the scale feature at compile time.
REQ-023 When defined, the result SHALL be ((A*B mod MOD)*NINV) mod MOD, via states SMUL and SRED, for inverse-NTT normalisation.
REQ-024 When undefined, states SMUL and SRED and the NINV multiplier SHALL not exist, and NINV SHALL be unused.

Verification
REQ-025 Basic product, DEPTH=8, A[i]=i+1, B[i]=2, macro off: after done, A = 2,4,6,8,10,12,14,16; done high 1 cycle; 50 cycles enable->done.
REQ-026 Overflow: A[0]=B[0]=MOD-1=998244352 -> A[0]=1; A[1]=2^31, B[1]=2^31 -> A[1]=(2^62) mod MOD.
REQ-027 Valid skew: b_valid arrives 3 cycles after a_valid for every element -> results correct; b_RE held until capture; a_WE pulses exactly 8 times.
REQ-028 Scale, macro on: A[i]=8, B[i]=1 -> every A[i]=1; 66 cycles enable->done.
REQ-029 Reset mid-run: assert rst during the WAIT of element 3 -> a_WE, busy and done go 0 at once; A[3..7] unchanged; re-enable completes all 8 correctly.
REQ-030 Enable pulsed during busy -> ignored: a single done and 8 writes only.
